// File: rtl/commit_unit_if.sv
// Data-memory store port of the commit unit.
// req rises with addr/wdata and all three hold until an edge that samples ack=1 (or the unit abandons the store).
interface commit_unit_if;
    logic        req;
    logic [9:0]  addr;
    logic [11:0] wdata;
    logic        ack;

    modport master (output req, output addr, output wdata, input ack);
    modport slave  (input req, input addr, input wdata, output ack);
endinterface

// File: rtl/commit_unit.sv
// Commit stage: retires the EC pipeline entry (register writeback, data-memory stores, retired count).
// While a store is in flight, stall_EC holds the EC register.
module commit_unit #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_store_EC,
    input  logic                 reg_write_en_EC,
    input  logic [3:0]           reg_write_addr_EC,
    input  logic [11:0]          execute_result_EC,
    input  logic [11:0]          store_data_EC,
    input  logic [11:0]          instruction_EC,
    output logic                 stall_EC,
    output logic                 rf_we,
    output logic [3:0]           rf_waddr,
    output logic [11:0]          rf_wdata,
    commit_unit_if.master        dmem,
    output logic                 store_err,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic [1:0]           state_dbg
);

    localparam logic [11:0] NOP_INSTR = 12'hB11;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [TW-1:0]         tcnt, tcnt_n;
    logic                  req_n;
    logic [9:0]            addr_n;
    logic [11:0]           wdata_n;
    logic                  err_n;
    logic [CNT_WIDTH-1:0]  cnt_n;
    logic                  we_n;
    logic [3:0]            waddr_n;
    logic [11:0]           wd_n;

    assign state_dbg = state;

    always_comb begin
        state_n  = state;
        tcnt_n   = tcnt;
        req_n    = dmem.req;
        addr_n   = dmem.addr;
        wdata_n  = dmem.wdata;
        err_n    = store_err;
        cnt_n    = retired_count;
        we_n     = 1'b0;
        waddr_n  = rf_waddr;
        wd_n     = rf_wdata;
        stall_EC = 1'b0;
        case (state)
            IDLE: begin
                if (mem_store_EC) begin
                    stall_EC = 1'b1;
                    req_n    = 1'b1;
                    addr_n   = execute_result_EC[9:0];
                    wdata_n  = store_data_EC;
                    tcnt_n   = '0;
                    state_n  = WAIT;
                end else begin
                    we_n = reg_write_en_EC;
                    if (reg_write_en_EC) begin
                        waddr_n = reg_write_addr_EC;
                        wd_n    = execute_result_EC;
                    end
                    if (instruction_EC != NOP_INSTR)
                        cnt_n = retired_count + CNT_WIDTH'(1);
                end
            end
            WAIT: begin
                stall_EC = 1'b1;
                // An ack on the timeout edge still counts as success.
                if (dmem.ack) begin
                    req_n   = 1'b0;
                    state_n = DRAIN;
                end else if (tcnt == TO_LAST) begin
                    req_n   = 1'b0;
                    err_n   = 1'b1;
                    state_n = DRAIN;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            DRAIN: begin
                // The store entry leaves EC here; mem_store_EC is deliberately not looked at.
                cnt_n = retired_count + CNT_WIDTH'(1);
                we_n  = reg_write_en_EC;
                if (reg_write_en_EC) begin
                    waddr_n = reg_write_addr_EC;
                    wd_n    = execute_result_EC;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            tcnt          <= '0;
            dmem.req      <= 1'b0;
            dmem.addr     <= '0;
            dmem.wdata    <= '0;
            store_err     <= 1'b0;
            retired_count <= '0;
            rf_we         <= 1'b0;
            rf_waddr      <= '0;
            rf_wdata      <= '0;
        end else begin
            state         <= state_n;
            tcnt          <= tcnt_n;
            dmem.req      <= req_n;
            dmem.addr     <= addr_n;
            dmem.wdata    <= wdata_n;
            store_err     <= err_n;
            retired_count <= cnt_n;
            rf_we         <= we_n;
            rf_waddr      <= waddr_n;
            rf_wdata      <= wd_n;
        end
    end

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit (ACK_TIMEOUT=4, CNT_WIDTH=4) with a transaction-level reference model.
module tb_commit_unit;
    localparam int AT = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_store_EC, reg_write_en_EC;
    logic [3:0]    reg_write_addr_EC;
    logic [11:0]   execute_result_EC, store_data_EC, instruction_EC;
    logic          stall_EC, rf_we, store_err;
    logic [3:0]    rf_waddr;
    logic [11:0]   rf_wdata;
    logic [CW-1:0] retired_count;
    logic [1:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    commit_unit_if dmem_bus ();

    commit_unit #(.ACK_TIMEOUT(AT), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_store_EC      (mem_store_EC),
        .reg_write_en_EC   (reg_write_en_EC),
        .reg_write_addr_EC (reg_write_addr_EC),
        .execute_result_EC (execute_result_EC),
        .store_data_EC     (store_data_EC),
        .instruction_EC    (instruction_EC),
        .stall_EC          (stall_EC),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .dmem              (dmem_bus.master),
        .store_err         (store_err),
        .retired_count     (retired_count),
        .state_dbg         (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic we, input logic [3:0] wa,
                         input logic [11:0] res, input logic [11:0] sd, input logic [11:0] ins);
        mem_store_EC      = st;
        reg_write_en_EC   = we;
        reg_write_addr_EC = wa;
        execute_result_EC = res;
        store_data_EC     = sd;
        instruction_EC    = ins;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a store is "pending" from launch until ack or AT ack-less edges,
    // then the entry retires on the following edge.
    logic          m_rf_we = 1'b0;
    logic [3:0]    m_rf_waddr = '0;
    logic [11:0]   m_rf_wdata = '0;
    logic          m_req = 1'b0;
    logic [9:0]    m_addr = '0;
    logic [11:0]   m_wdata = '0;
    logic          m_err = 1'b0;
    logic [CW-1:0] m_count = '0;
    logic          store_pending = 1'b0;
    logic          store_retiring = 1'b0;
    int            wait_edges = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rf_we = 1'b0; m_req = 1'b0; m_addr = '0; m_wdata = '0;
            m_err = 1'b0; m_count = '0; store_pending = 1'b0;
            store_retiring = 1'b0; wait_edges = 0;
        end else begin
            m_rf_we = 1'b0;
            if (store_retiring) begin
                store_retiring = 1'b0;
                m_count = m_count + 1'b1;
                if (reg_write_en_EC) begin
                    m_rf_we = 1'b1; m_rf_waddr = reg_write_addr_EC; m_rf_wdata = execute_result_EC;
                end
            end else if (store_pending) begin
                wait_edges = wait_edges + 1;
                if (dmem_bus.ack || wait_edges == AT) begin
                    if (!dmem_bus.ack) m_err = 1'b1;
                    m_req = 1'b0;
                    store_pending = 1'b0;
                    store_retiring = 1'b1;
                end
            end else if (mem_store_EC) begin
                m_req = 1'b1; m_addr = execute_result_EC[9:0]; m_wdata = store_data_EC;
                wait_edges = 0;
                store_pending = 1'b1;
            end else begin
                if (reg_write_en_EC) begin
                    m_rf_we = 1'b1; m_rf_waddr = reg_write_addr_EC; m_rf_wdata = execute_result_EC;
                end
                if (instruction_EC != 12'hB11) m_count = m_count + 1'b1;
            end
        end
    end

    // scoreboard compare, every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            chk("stall_EC", stall_EC, store_pending || (!store_retiring && mem_store_EC));
            chk("rf_we", rf_we, m_rf_we);
            if (m_rf_we) begin
                chk("rf_waddr", rf_waddr, m_rf_waddr);
                chk("rf_wdata", rf_wdata, m_rf_wdata);
            end
            chk("dmem_req", dmem_bus.req, m_req);
            if (m_req) begin
                chk("dmem_addr", dmem_bus.addr, m_addr);
                chk("dmem_wdata", dmem_bus.wdata, m_wdata);
            end
            chk("store_err", store_err, m_err);
            chk("retired_count", retired_count, m_count);
        end
    end

    // directed stimulus with hand-computed literals
    initial begin
        rst_n = 1'b1;
        dmem_bus.ack = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 12'h03A, 12'h055, 12'h0A5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", dmem_bus.req, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_err", store_err, 0);
        chk("rst_count", retired_count, 0);
        chk("rst_stall", stall_EC, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // store, ack on the second WAIT edge
        step();
        chk("st_req_up", dmem_bus.req, 1);
        chk("st_addr", dmem_bus.addr, 10'h03A);
        chk("st_wdata", dmem_bus.wdata, 12'h055);
        step();
        chk("st_req_hold", dmem_bus.req, 1);
        chk("st_addr_hold", dmem_bus.addr, 10'h03A);
        dmem_bus.ack = 1'b1;
        step();
        dmem_bus.ack = 1'b0;
        chk("st_req_down", dmem_bus.req, 0);
        chk("st_drain_stall", stall_EC, 0);
        chk("st_count_pre", retired_count, 0);
        step();
        drive(1'b0, 1'b1, 4'h5, 12'hABC, 12'h000, 12'h1F3);
        chk("st_no_relaunch", dmem_bus.req, 0);
        chk("st_count", retired_count, 1);

        // ALU commit
        step();
        chk("alu_we", rf_we, 1);
        chk("alu_waddr", rf_waddr, 4'h5);
        chk("alu_wdata", rf_wdata, 12'hABC);
        chk("alu_count", retired_count, 2);

        // ack arrives on the timeout edge
        drive(1'b1, 1'b0, 4'h0, 12'h2C4, 12'h777, 12'h0C0);
        repeat (4) step();
        chk("race_req_hold", dmem_bus.req, 1);
        dmem_bus.ack = 1'b1;
        step();
        dmem_bus.ack = 1'b0;
        chk("race_req_down", dmem_bus.req, 0);
        chk("race_no_err", store_err, 0);
        step();
        chk("race_count", retired_count, 3);

        // timeout store, drain entry also writes back
        drive(1'b1, 1'b0, 4'h0, 12'h200, 12'hFFF, 12'h0D0);
        step();
        chk("to_addr", dmem_bus.addr, 10'h200);
        repeat (3) step();
        chk("to_req_hold", dmem_bus.req, 1);
        step();
        chk("to_req_down", dmem_bus.req, 0);
        chk("to_err", store_err, 1);
        chk("to_stall", stall_EC, 0);
        drive(1'b1, 1'b1, 4'h7, 12'h200, 12'hFFF, 12'h0D0);
        step();
        chk("to_drain_we", rf_we, 1);
        chk("to_drain_wdata", rf_wdata, 12'h200);
        chk("to_count", retired_count, 4);
        drive(1'b0, 1'b1, 4'h2, 12'h123, 12'h000, 12'h222);
        step();
        chk("post_to_wdata", rf_wdata, 12'h123);
        chk("post_to_count", retired_count, 5);
        chk("err_sticky", store_err, 1);

        // NOP stream
        drive(1'b0, 1'b0, 4'h0, 12'h000, 12'h000, 12'hB11);
        repeat (5) step();
        chk("nop_we", rf_we, 0);
        chk("nop_count", retired_count, 5);

        // 17 commits wrap a 4-bit counter: 5 + 17 = 22 -> 6
        for (int i = 0; i < 17; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  12'($urandom_range(0, 4095)), 12'h000, 12'($urandom_range(0, 12'hB10)));
            step();
        end
        chk("wrap_count", retired_count, 6);

        // reset pulse in WAIT
        drive(1'b1, 1'b0, 4'h0, 12'h155, 12'h0AA, 12'h0E0);
        step();
        step();
        chk("rw_req_before", dmem_bus.req, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rw_req_async", dmem_bus.req, 0);
        chk("rw_state", state_dbg, 0);
        chk("rw_count", retired_count, 0);
        chk("rw_err", store_err, 0);
        drive(1'b0, 1'b1, 4'h9, 12'h456, 12'h000, 12'h333);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("rw_no_replay", dmem_bus.req, 0);
        chk("rw_alu_wdata", rf_wdata, 12'h456);
        chk("rw_alu_count", retired_count, 1);
        drive(1'b0, 1'b0, 4'h0, 12'h000, 12'h000, 12'hB11);
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
